// File: rtl/i_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : i_ram_loader
// Purpose  : UART boot loader for the instruction RAM. Parses the frame
//            A5, LEN_HI, LEN_LO, N x (HI, LO), CSUM. It writes 16-bit words
//            from address 0 and holds the CPU in reset until a complete,
//            checksum-valid image has been loaded.
// Revision : 1.0 - initial release
// ============================================================================
module i_ram_loader #(
  parameter int addr_width     = 12,
  parameter int timeout_cycles = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [addr_width-1:0] w_addr,
  output logic [15:0]           din,
  output logic                  w_en,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [7:0]        sync_byte = 8'hA5;
  localparam int                tcw       = $clog2(timeout_cycles + 1);
  localparam logic [tcw-1:0]    to_last   = tcw'(timeout_cycles - 1);
  localparam logic [32:0]       max_words = 33'd1 << addr_width;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic [7:0]            csum;
  logic [7:0]            len_hi;
  logic [7:0]            data_hi;
  logic [15:0]           remaining;
  logic [addr_width-1:0] addr;
  logic [tcw-1:0]        idle_cnt;

  logic                  active;
  logic                  timed_out;
  logic                  is_sync;
  logic [15:0]           len_word;
  logic                  too_big;

  // Next-state decode; a byte arriving in the timeout cycle takes priority.
  always_comb begin
    state_nx  = state;
    active    = (state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM});
    timed_out = active && !rx_valid && (idle_cnt == to_last);
    is_sync   = (rx_data == sync_byte);
    len_word  = {len_hi, rx_data};
    too_big   = ({17'b0, len_word} > max_words);

    case (state)
      S_IDLE:    if (rx_valid && is_sync) state_nx = S_LEN_HI;
      S_LEN_HI:  if (rx_valid) state_nx = S_LEN_LO;
      S_LEN_LO:  if (rx_valid) begin
                   if (too_big)              state_nx = S_ERROR;
                   else if (len_word == '0)  state_nx = S_CSUM;
                   else                      state_nx = S_DATA_HI;
                 end
      S_DATA_HI: if (rx_valid) state_nx = S_DATA_LO;
      S_DATA_LO: if (rx_valid) state_nx = (remaining == 16'd1) ? S_CSUM : S_DATA_HI;
      S_CSUM:    if (rx_valid) state_nx = (rx_data == csum) ? S_DONE : S_ERROR;
      S_DONE:    if (rx_valid && is_sync) state_nx = S_LEN_HI;
      S_ERROR:   state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase

    if (timed_out) state_nx = S_ERROR;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Datapath, checksum, inter-byte idle counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum      <= '0;
      len_hi    <= '0;
      data_hi   <= '0;
      remaining <= '0;
      addr      <= '0;
      idle_cnt  <= '0;
      w_addr    <= '0;
      din       <= '0;
      w_en      <= 1'b0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      w_en <= 1'b0;

      if (!active || rx_valid || timed_out) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + tcw'(1);

      if (rx_valid) begin
        case (state)
          S_IDLE, S_DONE: if (is_sync) begin
            csum      <= '0;
            load_err  <= 1'b0;
            load_done <= 1'b0;
            cpu_hold  <= 1'b1;
          end
          S_LEN_HI: begin
            len_hi <= rx_data;
            csum   <= csum + rx_data;
          end
          S_LEN_LO: begin
            csum      <= csum + rx_data;
            remaining <= len_word;
            addr      <= '0;
          end
          S_DATA_HI: begin
            data_hi <= rx_data;
            csum    <= csum + rx_data;
          end
          S_DATA_LO: begin
            csum      <= csum + rx_data;
            w_en      <= 1'b1;
            w_addr    <= addr;
            din       <= {data_hi, rx_data};
            // Wraps to 0 after the last word of a full-size image; harmless
            // because the FSM leaves DATA_LO on the same edge.
            addr      <= addr + addr_width'(1);
            remaining <= remaining - 16'd1;
          end
          S_CSUM: if (rx_data == csum) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (state == S_ERROR) load_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
